// File: rtl/daq_pkg.sv
// Shared DAQ constants and the collector state encoding.
package daq_pkg;
   localparam int DAQ_W = 32;
   localparam logic [DAQ_W-1:0] DAQ_ABORT_WORD = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_XFER  = 2'd1,
      ST_ABORT = 2'd2
   } daq_state_t;
endpackage

// File: rtl/daq_sync_fifo.sv
// Single-clock FIFO with registered storage and combinational head read.
module daq_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [AW:0]      r_count;
   logic             w_pop;

   assign w_pop   = i_pop && !o_empty;
   assign o_empty = (r_count == '0);
   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_count = r_count;
   assign o_rdata = r_mem[r_rptr];

   // Storage is not reset; pointer reset alone discards the contents.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst) i_push |-> !o_full);
endmodule

// File: rtl/daq_collector.sv
// Round-robin collector: grants one producer at a time and funnels its
// packet words (with end flag) into a FIFO for the downstream packetizer.
module daq_collector #(
   parameter int NSRC    = 4,
   parameter int DEPTH   = 64,
   parameter int MAXPKT  = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NSRC-1:0]           src_req,
   output logic [NSRC-1:0]           src_grant,
   input  logic [32*NSRC-1:0]        src_data,
   input  logic [NSRC-1:0]           src_valid,
   input  logic [NSRC-1:0]           src_end,
   output logic [31:0]               out_data,
   output logic                      out_end,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [$clog2(DEPTH):0]    fill,
   output logic [15:0]               abort_cnt,
   input  logic                      enable
);
   import daq_pkg::*;

   localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
   localparam int CW = $clog2(MAXPKT+1);
   localparam int TW = $clog2(TIMEOUT+1);
   localparam int FW = $clog2(DEPTH)+1;

   daq_state_t                  r_state, w_state_nxt;
   logic [SW-1:0]               r_cur, r_rr, w_win;
   logic [TW-1:0]               r_timer;
   logic [CW-1:0]               r_wcnt;
   logic [NSRC-1:0]             r_grant;
   logic [15:0]                 r_abort;
   logic                        w_any, w_room, w_grant;
   logic                        w_word, w_last, w_forced, w_push;
   logic [DAQ_W:0]              w_push_data, w_rdata;
   logic                        w_fifo_full, w_fifo_empty;
   logic [NSRC-1:0][DAQ_W-1:0]  w_src_words;

   assign w_src_words = src_data;

   // Scan from the highest offset down so the nearest requester at/after rr wins.
   always_comb begin
      int            j;
      logic [SW-1:0] idx;
      w_win = r_rr;
      w_any = 1'b0;
      j     = 0;
      idx   = '0;
      for (int k = NSRC-1; k >= 0; k--) begin
         j = int'(r_rr) + k;
         if (j >= NSRC) j = j - NSRC;
         idx = SW'(j);
         if (src_req[idx]) begin
            w_win = idx;
            w_any = 1'b1;
         end
      end
   end

   // One slot beyond a full packet is kept free for a possible abort terminator.
   assign w_room  = !w_fifo_full && ((FW'(DEPTH) - fill) >= FW'(MAXPKT+1));
   assign w_grant = (r_state == ST_IDLE) && enable && w_any && w_room;

   assign w_word   = (r_state == ST_XFER) && src_valid[r_cur];
   assign w_last   = src_end[r_cur] || (r_wcnt == CW'(MAXPKT-1));
   assign w_forced = w_word && !src_end[r_cur] && (r_wcnt == CW'(MAXPKT-1));
   assign w_push   = w_word || ((r_state == ST_ABORT) && (r_wcnt != '0));
   assign w_push_data = (r_state == ST_ABORT) ? {1'b1, DAQ_ABORT_WORD}
                                              : {w_last, w_src_words[r_cur]};

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_grant) w_state_nxt = ST_XFER;
         ST_XFER: begin
            if (w_word) begin
               if (w_last) w_state_nxt = ST_IDLE;
            end else if (r_timer == TW'(1)) begin
               w_state_nxt = ST_ABORT;
            end
         end
         ST_ABORT: w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cur   <= '0;
         r_rr    <= '0;
         r_timer <= '0;
         r_wcnt  <= '0;
         r_grant <= '0;
         r_abort <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= '0;
         if (w_grant) begin
            r_grant[w_win] <= 1'b1;
            r_cur          <= w_win;
            r_rr           <= (w_win == SW'(NSRC-1)) ? '0 : w_win + SW'(1);
            r_timer        <= TW'(TIMEOUT);
            r_wcnt         <= '0;
         end
         if (r_state == ST_XFER) begin
            if (w_word) begin
               r_wcnt  <= r_wcnt + CW'(1);
               r_timer <= TW'(TIMEOUT);
            end else begin
               r_timer <= r_timer - TW'(1);
            end
         end
         if ((w_forced || r_state == ST_ABORT) && r_abort != 16'hFFFF)
            r_abort <= r_abort + 16'd1;
      end
   end

   assign src_grant = r_grant;
   assign abort_cnt = r_abort;
   assign out_valid = !w_fifo_empty;
   assign {out_end, out_data} = w_rdata;

   daq_sync_fifo #(.WIDTH(DAQ_W+1), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (w_push_data),
      .i_pop   (out_ready),
      .o_rdata (w_rdata),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (fill)
   );
endmodule

// File: tb/tb_daq_collector.sv
// Randomized bench for daq_collector with a queue-based packet model.
module tb_daq_collector;
   localparam int NSRC = 4, DEPTH = 64, MAXPKT = 4, TIMEOUT = 16;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NSRC-1:0]      src_req, src_grant, src_valid, src_end;
   logic [32*NSRC-1:0]   src_data;
   logic [31:0]          out_data;
   logic                 out_end, out_valid, out_ready, enable;
   logic [6:0]           fill;
   logic [15:0]          abort_cnt;

   int          n_pass = 0, n_total = 0;
   logic [32:0] exp_q[$];
   int          model_rr = 0, model_abort = 0;

   always #5 clk = ~clk;

   daq_collector #(.NSRC(NSRC), .DEPTH(DEPTH), .MAXPKT(MAXPKT), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .src_req(src_req), .src_grant(src_grant), .src_data(src_data),
      .src_valid(src_valid), .src_end(src_end), .out_data(out_data), .out_end(out_end),
      .out_valid(out_valid), .out_ready(out_ready), .fill(fill), .abort_cnt(abort_cnt),
      .enable(enable));

   // Every popped word must be the oldest expected word.
   always @(negedge clk) begin
      logic [32:0] e;
      if (!rst && out_valid && out_ready) begin
         n_total++;
         if (exp_q.size() == 0)
            $display("FAIL fifo_out: got end=%0b data=%h, want no word", out_end, out_data);
         else begin
            e = exp_q.pop_front();
            if ({out_end, out_data} !== e)
               $display("FAIL fifo_out: got end=%0b data=%h, want end=%0b data=%h",
                        out_end, out_data, e[32], e[31:0]);
            else n_pass++;
         end
      end
   end

   function automatic int exp_winner(input logic [NSRC-1:0] req);
      for (int k = 0; k < NSRC; k++)
         if (req[(model_rr + k) % NSRC]) return (model_rr + k) % NSRC;
      return -1;
   endfunction

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic wait_grant(output int idx, output bit ok, input int bound);
      ok = 1'b0; idx = -1;
      for (int c = 0; c < bound && !ok; c++) begin
         @(negedge clk);
         if (src_grant != '0) begin
            ok = 1'b1;
            for (int i = 0; i < NSRC; i++) if (src_grant[i]) idx = i;
         end
      end
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         if (!out_valid) break;
      end
   endtask

   // Drives n words from source s; model: words past MAXPKT vanish and
   // word MAXPKT is stored as a terminator if the producer did not end there.
   task automatic send_pkt(input int s, input int n, input bit term, input int gap, input bit rdy_rand);
      logic [31:0] d;
      logic        e;
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, gap)) begin
            tick();
            src_valid = '0;
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
         end
         tick();
         if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
         d = $urandom;
         e = term && (i == n-1);
         src_data = {$urandom, $urandom, $urandom, $urandom};
         src_data[32*s +: 32] = d;
         src_valid = NSRC'($urandom); src_valid[s] = 1'b1;
         src_end   = NSRC'($urandom); src_end[s]   = e;
         if (i < MAXPKT) exp_q.push_back({e || (i == MAXPKT-1), d});
         if (i == MAXPKT-1 && !e) model_abort++;
      end
      tick();
      src_valid = '0; src_end = '0;
   endtask

   task automatic test_reset();
      src_req = '0; src_valid = '0; src_end = '0; src_data = '0;
      out_ready = 1'b1; enable = 1'b1; rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_total++; if (src_grant !== '0) $display("FAIL reset_grant: got %b want 0", src_grant); else n_pass++;
      n_total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
      n_total++; if (fill !== '0) $display("FAIL reset_fill: got %0d want 0", fill); else n_pass++;
      n_total++; if (abort_cnt !== '0) $display("FAIL reset_abort: got %0d want 0", abort_cnt); else n_pass++;
      tick(); rst = 1'b0;
   endtask

   task automatic test_single();
      int idx; bit ok;
      tick(); src_req = 4'b0010;
      wait_grant(idx, ok, 20);
      n_total++; if (!ok || idx != exp_winner(4'b0010)) $display("FAIL single_grant: got %0d want %0d", idx, exp_winner(4'b0010)); else n_pass++;
      n_total++; if (src_grant !== 4'b0010) $display("FAIL single_onehot: got %b want 0010", src_grant); else n_pass++;
      model_rr = 2;
      tick(); src_req = '0;
      src_valid = 4'b0010; src_end = '0; src_data = '0; src_data[63:32] = 32'h0A00_0012;
      exp_q.push_back({1'b0, 32'h0A00_0012});
      @(negedge clk);
      n_total++; if (src_grant !== '0) $display("FAIL single_pulse: got %b want 0", src_grant); else n_pass++;
      tick(); src_end = 4'b0010; src_data[63:32] = 32'h0000_1000;
      exp_q.push_back({1'b1, 32'h0000_1000});
      @(negedge clk);
      n_total++; if ({out_valid, out_end, out_data} !== {2'b10, 32'h0A00_0012}) $display("FAIL single_w0: got %b %b %h want 1 0 0a000012", out_valid, out_end, out_data); else n_pass++;
      tick(); src_valid = '0; src_end = '0;
      @(negedge clk);
      n_total++; if ({out_valid, out_end, out_data} !== {2'b11, 32'h0000_1000}) $display("FAIL single_w1: got %b %b %h want 1 1 00001000", out_valid, out_end, out_data); else n_pass++;
      @(negedge clk);
      n_total++; if (out_valid !== 1'b0) $display("FAIL single_empty: got %b want 0", out_valid); else n_pass++;
      n_total++; if (abort_cnt !== '0) $display("FAIL single_abort: got %0d want 0", abort_cnt); else n_pass++;
   endtask

   task automatic test_round_robin();
      int idx, w; bit ok;
      tick(); src_req = '1;
      for (int it = 0; it < 8; it++) begin
         w = exp_winner('1);
         wait_grant(idx, ok, 20);
         n_total++; if (!ok || idx != w) $display("FAIL rr_order: got %0d want %0d", idx, w); else n_pass++;
         if (!ok) break;
         model_rr = (idx + 1) % NSRC;
         send_pkt(idx, 1, 1'b1, 0, 1'b0);
      end
      src_req = '0;
   endtask

   task automatic test_random();
      int idx, w; bit ok;
      logic [NSRC-1:0] m;
      for (int it = 0; it < 20; it++) begin
         tick();
         m = NSRC'($urandom_range(1, (1 << NSRC) - 1));
         src_req = m;
         w = exp_winner(m);
         wait_grant(idx, ok, 20);
         n_total++; if (!ok || idx != w) $display("FAIL rand_grant: got %0d want %0d req=%b", idx, w, m); else n_pass++;
         if (!ok) break;
         model_rr = (idx + 1) % NSRC;
         src_req = '0;
         send_pkt(idx, $urandom_range(1, MAXPKT), 1'b1, 4, 1'b1);
      end
      n_total++; if (abort_cnt !== 16'(model_abort)) $display("FAIL rand_abort: got %0d want %0d", abort_cnt, model_abort); else n_pass++;
   endtask

   task automatic test_backpressure();
      int idx, cnt; bit ok; bit over;
      drain(); out_ready = 1'b0;
      tick(); src_req = '1;
      cnt = 0; over = 1'b0;
      for (int it = 0; it < 80; it++) begin
         wait_grant(idx, ok, 30);
         if (!ok) break;
         model_rr = (idx + 1) % NSRC;
         send_pkt(idx, 1, 1'b1, 0, 1'b0);
         cnt++;
         if (fill > 7'd60) over = 1'b1;
      end
      n_total++; if (over) $display("FAIL bp_overfill: got fill above 60 want <=60"); else n_pass++;
      n_total++; if (cnt != 60) $display("FAIL bp_grants: got %0d want 60", cnt); else n_pass++;
      n_total++; if (fill !== 7'd60) $display("FAIL bp_fill: got %0d want 60", fill); else n_pass++;
      tick(); out_ready = 1'b1;
      wait_grant(idx, ok, 30);
      n_total++; if (!ok) $display("FAIL bp_resume: got no grant want grant"); else n_pass++;
      if (ok) begin
         model_rr = (idx + 1) % NSRC;
         send_pkt(idx, 1, 1'b1, 0, 1'b0);
      end
      src_req = '0;
   endtask

   task automatic test_timeout();
      int idx, n; bit ok, hit;
      drain();
      tick(); src_req = 4'b0100;
      wait_grant(idx, ok, 20);
      n_total++; if (!ok || idx != exp_winner(4'b0100)) $display("FAIL to_grant: got %0d want %0d", idx, exp_winner(4'b0100)); else n_pass++;
      model_rr = (idx + 1) % NSRC; src_req = '0;
      send_pkt(idx, 1, 1'b0, 0, 1'b0);
      model_abort++;
      exp_q.push_back({1'b1, 32'hFFFF_FFFF});
      n = 0; hit = 1'b0;
      while (n < 40 && !hit) begin
         @(negedge clk); n++;
         if (abort_cnt == 16'(model_abort)) hit = 1'b1;
      end
      n_total++; if (!hit || n < 16 || n > 19) $display("FAIL to_abort: got hit=%0b after %0d cycles want 16..19", hit, n); else n_pass++;
      tick(); src_req = 4'b1000;
      wait_grant(idx, ok, 20);
      n_total++; if (!ok || idx != exp_winner(4'b1000)) $display("FAIL to_grant0: got %0d want %0d", idx, exp_winner(4'b1000)); else n_pass++;
      model_rr = (idx + 1) % NSRC; src_req = '0;
      model_abort++;
      n = 0; hit = 1'b0;
      while (n < 40 && !hit) begin
         @(negedge clk); n++;
         if (abort_cnt == 16'(model_abort)) hit = 1'b1;
      end
      n_total++; if (!hit) $display("FAIL to_abort0: got %0d want %0d", abort_cnt, model_abort); else n_pass++;
      repeat (3) @(negedge clk);
      n_total++; if (out_valid !== 1'b0 || fill !== '0) $display("FAIL to_noword: got valid=%b fill=%0d want 0 0", out_valid, fill); else n_pass++;
   endtask

   task automatic test_overlong();
      int idx, s; bit ok;
      s = $urandom_range(0, NSRC-1);
      tick(); src_req = NSRC'(1 << s);
      wait_grant(idx, ok, 20);
      n_total++; if (!ok || idx != s) $display("FAIL long_grant: got %0d want %0d", idx, s); else n_pass++;
      model_rr = (idx + 1) % NSRC; src_req = '0;
      send_pkt(s, 5, 1'b0, 0, 1'b0);
      repeat (4) @(negedge clk);
      n_total++; if (abort_cnt !== 16'(model_abort)) $display("FAIL long_abort: got %0d want %0d", abort_cnt, model_abort); else n_pass++;
      n_total++; if (exp_q.size() != 0) $display("FAIL long_stored: got %0d words left want 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_enable();
      int idx, s, g; bit ok;
      s = $urandom_range(0, NSRC-1);
      tick(); src_req = NSRC'(1 << s); enable = 1'b1;
      wait_grant(idx, ok, 20);
      n_total++; if (!ok || idx != s) $display("FAIL en_grant: got %0d want %0d", idx, s); else n_pass++;
      model_rr = (idx + 1) % NSRC;
      enable = 1'b0;
      send_pkt(s, 2, 1'b1, 2, 1'b0);
      g = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (src_grant != '0) g++;
      end
      n_total++; if (g != 0) $display("FAIL en_block: got %0d grant cycles want 0", g); else n_pass++;
      n_total++; if (exp_q.size() != 0) $display("FAIL en_complete: got %0d words pending want 0", exp_q.size()); else n_pass++;
      tick(); enable = 1'b1;
      wait_grant(idx, ok, 20);
      n_total++; if (!ok || idx != s) $display("FAIL en_resume: got %0d want %0d", idx, s); else n_pass++;
      model_rr = (idx + 1) % NSRC; src_req = '0;
      send_pkt(s, 1, 1'b1, 0, 1'b0);
   endtask

   task automatic test_rst_mid();
      int idx; bit ok;
      drain(); out_ready = 1'b0;
      tick(); src_req = 4'b0001;
      wait_grant(idx, ok, 20);
      n_total++; if (!ok || idx != 0) $display("FAIL rst_grant: got %0d want 0", idx); else n_pass++;
      src_req = '1;
      tick(); src_valid = 4'b0001; src_end = '0; src_data[31:0] = $urandom;
      tick(); src_valid = '0; rst = 1'b1;
      tick(); rst = 1'b0;
      exp_q.delete(); model_rr = 0; model_abort = 0;
      @(negedge clk);
      n_total++; if ({fill, out_valid, src_grant} !== '0) $display("FAIL rst_clear: got fill=%0d valid=%b grant=%b want 0 0 0", fill, out_valid, src_grant); else n_pass++;
      wait_grant(idx, ok, 20);
      n_total++; if (!ok || idx != exp_winner('1)) $display("FAIL rst_rr: got %0d want %0d", idx, exp_winner('1)); else n_pass++;
      model_rr = (idx + 1) % NSRC; src_req = '0;
      out_ready = 1'b1;
      send_pkt(idx, 1, 1'b1, 0, 1'b0);
      n_total++; if (abort_cnt !== '0) $display("FAIL rst_abort: got %0d want 0", abort_cnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_random();
      test_backpressure();
      test_timeout();
      test_overlong();
      test_enable();
      test_rst_mid();
      drain();
      repeat (2) @(negedge clk);
      n_total++; if (exp_q.size() != 0 || out_valid !== 1'b0) $display("FAIL final_drain: got %0d pending valid=%b want 0 0", exp_q.size(), out_valid); else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
